// File: rtl/egg_timer_controller_if.sv
// Front-panel / setting-bank / display bundle for the egg timer controller.
// Buttons are debounced one-cycle pulses; setD is sampled every cycle and all outputs are registered-state decodes.
interface egg_timer_controller_if;
  logic       setBtn;
  logic       startBtn;
  logic       stopBtn;
  logic [3:0] setD0;
  logic [3:0] setD1;
  logic [3:0] setD2;
  logic [3:0] setD3;
  logic       isSecond;
  logic       isMinute;
  logic [3:0] disp0;
  logic [3:0] disp1;
  logic [3:0] disp2;
  logic [3:0] disp3;
  logic       running;
  logic       alarm;
  logic [2:0] state;

  modport slave (
    input  setBtn, startBtn, stopBtn, setD0, setD1, setD2, setD3,
    output isSecond, isMinute, disp0, disp1, disp2, disp3, running, alarm, state
  );

  modport master (
    output setBtn, startBtn, stopBtn, setD0, setD1, setD2, setD3,
    input  isSecond, isMinute, disp0, disp1, disp2, disp3, running, alarm, state
  );
endinterface

// File: rtl/egg_timer_controller.sv
// Egg timer sequencer: setting-mode strobes, MM:SS BCD countdown from a prescaled tick,
// and a timed alarm at 00:00. Outputs are Moore decodes of the registered state.
module egg_timer_controller #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  egg_timer_controller_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_SEC = 3'd1,
    SET_MIN = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alm_q, alm_d;

  logic [15:0] setd;
  logic [15:0] dec;
  logic        b0, b1, b2;
  logic        tick;
  logic        any_btn;

  assign setd    = {bus.setD3, bus.setD2, bus.setD1, bus.setD0};
  assign any_btn = bus.setBtn | bus.startBtn | bus.stopBtn;
  assign tick    = ((state_q == RUN) || (state_q == DONE)) && (presc_q == PRESC_LAST);

  // BCD borrow chain: seconds tens wrap to 5, other digits wrap to 9.
  always_comb begin
    b0         = (cnt_q[3:0] == 4'd0);
    b1         = b0 && (cnt_q[7:4] == 4'd0);
    b2         = b1 && (cnt_q[11:8] == 4'd0);
    dec[3:0]   = b0 ? 4'd9 : cnt_q[3:0] - 4'd1;
    dec[7:4]   = b0 ? ((cnt_q[7:4] == 4'd0) ? 4'd5 : cnt_q[7:4] - 4'd1) : cnt_q[7:4];
    dec[11:8]  = b1 ? ((cnt_q[11:8] == 4'd0) ? 4'd9 : cnt_q[11:8] - 4'd1) : cnt_q[11:8];
    dec[15:12] = b2 ? cnt_q[15:12] - 4'd1 : cnt_q[15:12];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      alm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      alm_q   <= alm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    alm_d   = alm_q;
    // The prescaler advances on every RUN/DONE edge, including the edge that pauses.
    if ((state_q == RUN) || (state_q == DONE))
      presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      IDLE, SET_SEC, SET_MIN: begin
        if (bus.stopBtn) begin
          state_d = IDLE;
        end else if (bus.startBtn) begin
          if (setd != 16'h0000) begin
            state_d = RUN;
            cnt_d   = setd;
            presc_d = '0;
          end
        end else if (bus.setBtn) begin
          case (state_q)
            IDLE:    state_d = SET_SEC;
            SET_SEC: state_d = SET_MIN;
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        if (bus.stopBtn) begin
          state_d = PAUSE;
        end else if (tick) begin
          cnt_d = dec;
          if (dec == 16'h0000) state_d = DONE;
        end
      end
      PAUSE: begin
        if (bus.stopBtn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.startBtn) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (any_btn || (tick && (alm_q == ALARM_LAST))) begin
          state_d = IDLE;
          alm_d   = '0;
          presc_d = '0;
        end else if (tick) begin
          alm_d = alm_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [15:0] disp;

  always_comb begin
    bus.isSecond = 1'b0;
    bus.isMinute = 1'b0;
    bus.running  = 1'b0;
    bus.alarm    = 1'b0;
    disp         = setd;
    case (state_q)
      SET_SEC: bus.isSecond = 1'b1;
      SET_MIN: bus.isMinute = 1'b1;
      RUN: begin
        bus.running = 1'b1;
        disp        = cnt_q;
      end
      PAUSE:   disp = cnt_q;
      DONE: begin
        bus.alarm = 1'b1;
        disp      = 16'h0000;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;
  assign bus.disp0 = disp[3:0];
  assign bus.disp1 = disp[7:4];
  assign bus.disp2 = disp[11:8];
  assign bus.disp3 = disp[15:12];
endmodule

// File: tb/tb_egg_timer_controller.sv
// Directed bench for egg_timer_controller with TICK_DIV=4, ALARM_TICKS=3.
// Inputs change and outputs are sampled on the falling edge; "+k" means k rising edges after the pulse edge.
module tb_egg_timer_controller;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  egg_timer_controller_if et_if();

  egg_timer_controller #(
    .TICK_DIV   (4),
    .ALARM_TICKS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (et_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] disp_v();
    return {et_if.disp3, et_if.disp2, et_if.disp1, et_if.disp0};
  endfunction

  function automatic logic [15:0] flags_v();
    return {12'h000, et_if.isSecond, et_if.isMinute, et_if.running, et_if.alarm};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: caller sits on a falling edge; the pulse is sampled on the next rising edge
  task automatic set_digits(input logic [15:0] v);
    et_if.setD0 = v[3:0];
    et_if.setD1 = v[7:4];
    et_if.setD2 = v[11:8];
    et_if.setD3 = v[15:12];
  endtask

  task automatic press(input logic s, input logic st, input logic sp);
    et_if.setBtn   = s;
    et_if.startBtn = st;
    et_if.stopBtn  = sp;
    @(negedge clk);
    et_if.setBtn   = 1'b0;
    et_if.startBtn = 1'b0;
    et_if.stopBtn  = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    et_if.setBtn   = 1'b0;
    et_if.startBtn = 1'b0;
    et_if.stopBtn  = 1'b0;
    set_digits(16'h5959);
    reset = 1'b1;
    #2 reset = 1'b0;
    wait_n(2);

    // reset state
    check("rst_state", {13'h0, et_if.state}, 16'h0000);
    check("rst_flags", flags_v(), 16'h0000);
    check("rst_disp", disp_v(), 16'h5959);
    reset = 1'b1;
    wait_n(1);

    // set-mode cycling, stop ignored in IDLE
    press(1'b0, 1'b0, 1'b1);
    check("idle_stop_ignored", {13'h0, et_if.state}, 16'h0000);
    press(1'b1, 1'b0, 1'b0);
    check("set1_state", {13'h0, et_if.state}, 16'h0001);
    check("set1_flags", flags_v(), 16'h0008);
    press(1'b1, 1'b0, 1'b0);
    check("set2_state", {13'h0, et_if.state}, 16'h0002);
    check("set2_flags", flags_v(), 16'h0004);
    check("set2_disp", disp_v(), 16'h5959);
    press(1'b1, 1'b0, 1'b0);
    check("set3_state", {13'h0, et_if.state}, 16'h0000);
    check("set3_flags", flags_v(), 16'h0000);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("setsec_stop", {13'h0, et_if.state}, 16'h0000);

    // zero start rejected
    set_digits(16'h0000);
    press(1'b0, 1'b1, 1'b0);
    check("zero_start_state", {13'h0, et_if.state}, 16'h0000);
    check("zero_start_flags", flags_v(), 16'h0000);

    // borrow chain 01:01
    set_digits(16'h0101);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0059);
    exp_q.push_back(16'h0058);
    press(1'b0, 1'b1, 1'b0);
    check("run_state", {13'h0, et_if.state}, 16'h0003);
    check("run_flags", flags_v(), 16'h0002);
    wait_n(3);
    check("run_disp_p3", disp_v(), 16'h0101);
    for (int i = 0; i < 3; i++) begin
      wait_n(1);
      exp_v = exp_q.pop_front();
      check("run_disp_tick", disp_v(), exp_v);
      if (i < 2) wait_n(3);
    end
    wait_n(243 - 12);
    check("done_pre_state", {13'h0, et_if.state}, 16'h0003);
    check("done_pre_disp", disp_v(), 16'h0001);
    wait_n(1);
    check("done_state", {13'h0, et_if.state}, 16'h0005);
    check("done_flags", flags_v(), 16'h0001);
    check("done_disp", disp_v(), 16'h0000);
    wait_n(11);
    check("alarm_last_cycle", flags_v(), 16'h0001);
    wait_n(1);
    check("alarm_exit_state", {13'h0, et_if.state}, 16'h0000);
    check("alarm_exit_disp", disp_v(), 16'h0101);

    // pause/resume 00:05
    set_digits(16'h0005);
    press(1'b0, 1'b1, 1'b0);
    wait_n(4);
    check("pr_p4", disp_v(), 16'h0004);
    wait_n(1);
    press(1'b0, 1'b0, 1'b1);
    check("pr_pause_state", {13'h0, et_if.state}, 16'h0004);
    wait_n(9);
    check("pr_p15_state", {13'h0, et_if.state}, 16'h0004);
    check("pr_p15_disp", disp_v(), 16'h0004);
    press(1'b0, 1'b1, 1'b0);
    check("pr_resume_state", {13'h0, et_if.state}, 16'h0003);
    wait_n(1);
    check("pr_p17", disp_v(), 16'h0004);
    wait_n(1);
    check("pr_p18", disp_v(), 16'h0003);

    // start+stop together in RUN -> PAUSE, then stop -> IDLE
    press(1'b0, 1'b1, 1'b1);
    check("simul_state", {13'h0, et_if.state}, 16'h0004);
    press(1'b0, 1'b0, 1'b1);
    check("pause_stop_state", {13'h0, et_if.state}, 16'h0000);

    // stop on the tick cycle suppresses the decrement
    press(1'b0, 1'b1, 1'b0);
    wait_n(3);
    press(1'b0, 1'b0, 1'b1);
    check("tick_stop_state", {13'h0, et_if.state}, 16'h0004);
    check("tick_stop_disp", disp_v(), 16'h0005);
    press(1'b0, 1'b0, 1'b1);

    // set pulse in DONE returns to IDLE
    set_digits(16'h0001);
    press(1'b0, 1'b1, 1'b0);
    wait_n(4);
    check("done2_state", {13'h0, et_if.state}, 16'h0005);
    wait_n(1);
    press(1'b1, 1'b0, 1'b0);
    check("done_set_state", {13'h0, et_if.state}, 16'h0000);
    check("done_set_flags", flags_v(), 16'h0000);

    // asynchronous reset in RUN
    set_digits(16'h0005);
    press(1'b0, 1'b1, 1'b0);
    wait_n(2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", {13'h0, et_if.state}, 16'h0000);
    check("async_rst_flags", flags_v(), 16'h0000);
    check("async_rst_disp", disp_v(), 16'h0005);
    wait_n(1);
    reset = 1'b1;
    wait_n(2);
    check("post_rst_state", {13'h0, et_if.state}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
